// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory bus.
// slave = the LSU's view; master = execute stage plus data memory.
interface load_store_unit_if #(
  parameter int DMEM_AW = 14
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_funct3;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               resp_valid;
  logic               resp_err;
  logic [31:0]        resp_rdata;
  logic               dmem_wen;
  logic [DMEM_AW-1:0] dmem_waddr;
  logic [31:0]        dmem_wdata;
  logic               dmem_ren;
  logic [DMEM_AW-1:0] dmem_raddr;
  logic [31:0]        dmem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, dmem_rdata,
    output req_ready, resp_valid, resp_err,
    output resp_rdata, dmem_wen, dmem_waddr,
    output dmem_wdata, dmem_ren, dmem_raddr
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, dmem_rdata,
    input  req_ready, resp_valid, resp_err,
    input  resp_rdata, dmem_wen, dmem_waddr,
    input  dmem_wdata, dmem_ren, dmem_raddr
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator, one request in flight.
// Ports: clk; rst (async, active-high); bus (load_store_unit_if.slave):
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata in,
//   resp_valid/resp_err/resp_rdata out, dmem_* strobes out,
//   dmem_rdata in (1-cycle registered read of a word-wide memory).
// Build macro LSU_SUBWORD_EN: B/H/BU/HU access and store RMW path.
module load_store_unit #(
  parameter int DMEM_AW = 14
) (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] F3_W = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LDATA,
    S_MERGE,
    S_WR,
    S_ERR
  } state_t;

  state_t             state;
  logic [DMEM_AW-1:0] wa_q;
  logic [31:0]        wdata_q;

  logic is_w;
  logic hi_bad;
  logic f3_bad;
  logic algn_bad;
  logic req_err;
  logic [31:0] ext;
  logic [31:0] wr_word;

  assign is_w   = bus.req_funct3 == F3_W;
  assign hi_bad = |bus.req_addr[31:DMEM_AW+2];

`ifdef LSU_SUBWORD_EN
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] lane_q;

  logic is_b;
  logic is_h;
  logic is_bu;
  logic is_hu;

  assign is_b  = bus.req_funct3 == F3_B;
  assign is_h  = bus.req_funct3 == F3_H;
  assign is_bu = bus.req_funct3 == F3_BU;
  assign is_hu = bus.req_funct3 == F3_HU;

  // Unsigned variants exist for loads only.
  always_comb begin
    f3_bad   = 1'b0;
    algn_bad = 1'b0;
    unique case (1'b1)
      is_b:  f3_bad = 1'b0;
      is_h:  algn_bad = bus.req_addr[0];
      is_hu: begin
        f3_bad   = bus.req_we;
        algn_bad = bus.req_addr[0];
      end
      is_bu: f3_bad = bus.req_we;
      is_w:  algn_bad = |bus.req_addr[1:0];
      default: f3_bad = 1'b1;
    endcase
  end
`else
  assign f3_bad   = !is_w;
  assign algn_bad = |bus.req_addr[1:0];
`endif

  assign req_err = hi_bad | f3_bad | algn_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wa_q    <= '0;
      wdata_q <= '0;
`ifdef LSU_SUBWORD_EN
      we_q    <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            wa_q    <= bus.req_addr[DMEM_AW+1:2];
            wdata_q <= bus.req_wdata;
`ifdef LSU_SUBWORD_EN
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            lane_q  <= bus.req_addr[1:0];
`endif
            if (req_err)
              state <= S_ERR;
            else if (bus.req_we & is_w)
              state <= S_WR;
            else
              state <= S_RD;
          end
        end
`ifdef LSU_SUBWORD_EN
        S_RD:    state <= we_q ? S_MERGE : S_LDATA;
`else
        S_RD:    state <= S_LDATA;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_SUBWORD_EN
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] merged;

  assign shifted  = bus.dmem_rdata >> {lane_q, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = lane_q[1] ? bus.dmem_rdata[31:16]
                              : bus.dmem_rdata[15:0];

  always_comb begin
    ext = bus.dmem_rdata;
    unique case (1'b1)
      f3_q == F3_B:  ext = {{24{byte_sel[7]}}, byte_sel};
      f3_q == F3_BU: ext = {24'h0, byte_sel};
      f3_q == F3_H:  ext = {{16{half_sel[15]}}, half_sel};
      f3_q == F3_HU: ext = {16'h0, half_sel};
      default:       ext = bus.dmem_rdata;
    endcase
  end

  // Only SB and SH reach MERGE, so f3_q[0] separates half from byte.
  always_comb begin
    merged = bus.dmem_rdata;
    if (f3_q[0]) begin
      if (lane_q[1])
        merged[31:16] = wdata_q[15:0];
      else
        merged[15:0] = wdata_q[15:0];
    end else begin
      unique case (lane_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  assign wr_word = (state == S_MERGE) ? merged : wdata_q;
`else
  assign ext     = bus.dmem_rdata;
  assign wr_word = wdata_q;
`endif

  assign bus.req_ready  = state == S_IDLE;
  assign bus.resp_valid = state inside {S_LDATA, S_MERGE, S_WR, S_ERR};
  assign bus.resp_err   = state == S_ERR;
  assign bus.resp_rdata = (state == S_LDATA) ? ext : 32'h0;
  assign bus.dmem_ren   = state == S_RD;
  assign bus.dmem_wen   = (state == S_WR) | (state == S_MERGE);
  assign bus.dmem_raddr = wa_q;
  assign bus.dmem_waddr = wa_q;
  assign bus.dmem_wdata = bus.dmem_wen ? wr_word : 32'h0;
endmodule
